// File: rtl/cnt_stream_checker_if.sv
// cnt_stream_checker_if -- sample/status bundle for the counter stream checker.
//   en         sample strobe (data_in only looked at when high)
//   data_in    received counter byte
//   clear      synchronous clear of the error/good statistics
//   locked     checker is in LOCKED
//   state      FSM encoding (IDLE=00, ACQUIRE=01, LOCKED=10, LOST=11)
//   err_cnt    saturating mismatch count while locked
//   good_cnt   saturating match count while locked
//   err_sticky any mismatch seen while locked since last clear/reset
// slave modport faces the checker, master modport faces the stimulus side.
interface cnt_stream_checker_if;
    logic        en;
    logic [7:0]  data_in;
    logic        clear;
    logic        locked;
    logic [1:0]  state;
    logic [7:0]  err_cnt;
    logic [15:0] good_cnt;
    logic        err_sticky;

    modport slave (
        input  en, data_in, clear,
        output locked, state, err_cnt, good_cnt, err_sticky
    );

    modport master (
        output en, data_in, clear,
        input  locked, state, err_cnt, good_cnt, err_sticky
    );
endinterface

// File: rtl/cnt_stream_checker.sv
// cnt_stream_checker -- locks onto an incrementing 8-bit counter stream and
// keeps match/mismatch statistics while locked.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (release is synchronous upstream)
//   bus    cnt_stream_checker_if.slave: en/data_in/clear in,
//          locked/state/err_cnt/good_cnt/err_sticky out (all registered)
// LOCK_N consecutive matches acquire lock; LOSS_N consecutive mismatches
// while locked drop it.
module cnt_stream_checker #(
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cnt_stream_checker_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10,
        LOST    = 2'b11
    } state_e;

    localparam logic [3:0] LOCK_C = LOCK_N[3:0];
    localparam logic [3:0] LOSS_C = LOSS_N[3:0];

    state_e      state_q, state_d;
    logic [7:0]  exp_q, exp_d;
    logic [3:0]  run_q, run_d;
    logic [3:0]  miss_q, miss_d;
    logic [7:0]  err_cnt_q;
    logic [15:0] good_cnt_q;
    logic        err_sticky_q;

    logic        match;
    logic [3:0]  run_inc;
    logic [3:0]  miss_inc;
    logic        locked_sample;

    assign match         = (bus.data_in == exp_q);
    assign run_inc       = run_q + 4'd1;
    assign miss_inc      = miss_q + 4'd1;
    assign locked_sample = bus.en && (state_q == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            exp_q   <= 8'd0;
            run_q   <= 4'd0;
            miss_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            run_q   <= run_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        run_d   = run_q;
        miss_d  = miss_q;
        if (bus.en) begin
            unique case (state_q)
                IDLE: begin
                    exp_d   = bus.data_in + 8'd1;
                    run_d   = 4'd1;
                    miss_d  = 4'd0;
                    state_d = (LOCK_C == 4'd1) ? LOCKED : ACQUIRE;
                end
                ACQUIRE: begin
                    if (match) begin
                        exp_d = exp_q + 8'd1;
                        run_d = run_inc;
                        if (run_inc >= LOCK_C) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        // Reseed on the offending byte; it becomes sample 1 of a new run.
                        exp_d = bus.data_in + 8'd1;
                        run_d = 4'd1;
                    end
                end
                LOCKED: begin
                    // Locked tracking never reseeds: a corrupted byte must not shift exp.
                    exp_d = exp_q + 8'd1;
                    if (match) begin
                        miss_d = 4'd0;
                    end else begin
                        miss_d = miss_inc;
                        if (miss_inc >= LOSS_C) state_d = LOST;
                    end
                end
                LOST: begin
                    exp_d   = bus.data_in + 8'd1;
                    run_d   = 4'd1;
                    miss_d  = 4'd0;
                    state_d = ACQUIRE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Statistics: clear beats a same-edge locked sample; lock FSM is unaffected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q    <= 8'd0;
            good_cnt_q   <= 16'd0;
            err_sticky_q <= 1'b0;
        end else if (bus.clear) begin
            err_cnt_q    <= 8'd0;
            good_cnt_q   <= 16'd0;
            err_sticky_q <= 1'b0;
        end else if (locked_sample) begin
            if (match) begin
                if (good_cnt_q != 16'hFFFF) good_cnt_q <= good_cnt_q + 16'd1;
            end else begin
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                err_sticky_q <= 1'b1;
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.locked     = (state_q == LOCKED);
    assign bus.err_cnt    = err_cnt_q;
    assign bus.good_cnt   = good_cnt_q;
    assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_cnt_stream_checker.sv
// tb_cnt_stream_checker -- directed bench for cnt_stream_checker with
// default parameters (LOCK_N=4, LOSS_N=3).
module tb_cnt_stream_checker;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    logic [7:0] e;

    cnt_stream_checker_if ifc ();

    cnt_stream_checker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic lk,
                           input logic [7:0] err, input logic [15:0] good, input logic sticky);
        chk({tag, ".state"},  {14'd0, ifc.state},     {14'd0, st});
        chk({tag, ".locked"}, {15'd0, ifc.locked},    {15'd0, lk});
        chk({tag, ".err"},    {8'd0, ifc.err_cnt},    {8'd0, err});
        chk({tag, ".good"},   ifc.good_cnt,           good);
        chk({tag, ".sticky"}, {15'd0, ifc.err_sticky}, {15'd0, sticky});
    endtask

    // Drive one cycle of inputs, sample outputs 1 time unit after the edge.
    task automatic step(input logic en_i, input logic [7:0] d, input logic clr);
        ifc.en      = en_i;
        ifc.data_in = d;
        ifc.clear   = clr;
        @(posedge clk);
        #1;
        ifc.en    = 1'b0;
        ifc.clear = 1'b0;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        ifc.en      = 1'b0;
        ifc.data_in = 8'h00;
        ifc.clear   = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 2'b00, 1'b0, 8'h00, 16'd0, 1'b0);
        rst_n = 1'b1;

        // IDLE ignores en=0
        step(1'b0, 8'h33, 1'b0);
        chk("idle_en0", {14'd0, ifc.state}, 16'd0);

        // Acquisition 10..14
        step(1'b1, 8'd10, 1'b0); chk_all("acq10", 2'b01, 1'b0, 8'h00, 16'd0, 1'b0);
        step(1'b1, 8'd11, 1'b0); chk("acq11", {14'd0, ifc.state}, 16'd1);
        step(1'b1, 8'd12, 1'b0); chk("acq12", {14'd0, ifc.state}, 16'd1);
        step(1'b1, 8'd13, 1'b0); chk_all("lock13", 2'b10, 1'b1, 8'h00, 16'd0, 1'b0);
        step(1'b1, 8'd14, 1'b0); chk_all("good14", 2'b10, 1'b1, 8'h00, 16'd1, 1'b0);

        // Run up to 0xFC, then wrap 0xFD..0x01
        for (int d = 15; d <= 252; d++) step(1'b1, d[7:0], 1'b0);
        chk_all("pre_wrap", 2'b10, 1'b1, 8'h00, 16'd239, 1'b0);
        for (int d = 253; d <= 257; d++) step(1'b1, d[7:0], 1'b0);
        chk_all("wrap", 2'b10, 1'b1, 8'h00, 16'd244, 1'b0);

        // Single injected error at exp=0x20
        for (int d = 2; d <= 31; d++) step(1'b1, d[7:0], 1'b0);
        chk("good_at_20", ifc.good_cnt, 16'd274);
        step(1'b1, 8'h55, 1'b0); chk_all("inject", 2'b10, 1'b1, 8'h01, 16'd274, 1'b1);
        step(1'b1, 8'h21, 1'b0);
        step(1'b1, 8'h22, 1'b0); chk_all("recover", 2'b10, 1'b1, 8'h01, 16'd276, 1'b1);

        // Three consecutive misses -> LOST
        step(1'b1, 8'h00, 1'b0); chk_all("miss1", 2'b10, 1'b1, 8'h02, 16'd276, 1'b1);
        step(1'b1, 8'h00, 1'b0); chk("miss2", {14'd0, ifc.state}, 16'd2);
        step(1'b1, 8'h00, 1'b0); chk_all("lost", 2'b11, 1'b0, 8'h04, 16'd276, 1'b1);
        step(1'b0, 8'h99, 1'b0); chk("lost_en0", {14'd0, ifc.state}, 16'd3);
        step(1'b1, 8'h40, 1'b0); chk_all("reseed40", 2'b01, 1'b0, 8'h04, 16'd276, 1'b1);
        // exp must be 0x41: three further matches complete the 4-sample run
        step(1'b1, 8'h41, 1'b0); chk("run41", {14'd0, ifc.state}, 16'd1);
        step(1'b1, 8'h42, 1'b0); chk("run42", {14'd0, ifc.state}, 16'd1);
        step(1'b1, 8'h43, 1'b0); chk_all("relock43", 2'b10, 1'b1, 8'h04, 16'd276, 1'b1);
        e = 8'h44;

        // Clear without a sample
        step(1'b0, 8'hAA, 1'b1); chk_all("clear0", 2'b10, 1'b1, 8'h00, 16'd0, 1'b0);

        // Drive err_cnt to 0xFE with alternating miss/match, staying locked
        for (int i = 0; i < 254; i++) begin
            step(1'b1, e ^ 8'h80, 1'b0); e++;
            step(1'b1, e, 1'b0);         e++;
        end
        chk_all("err_fe", 2'b10, 1'b1, 8'hFE, 16'd254, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, e ^ 8'h80, 1'b0); e++;
            step(1'b1, e, 1'b0);         e++;
        end
        chk_all("err_sat", 2'b10, 1'b1, 8'hFF, 16'd257, 1'b1);

        // Clear coincident with a locked matching sample: clear wins
        step(1'b1, e, 1'b1); e++;
        chk_all("clear_win", 2'b10, 1'b1, 8'h00, 16'd0, 1'b0);
        step(1'b1, e, 1'b0); e++;
        chk("post_clear", ifc.good_cnt, 16'd1);

        // en=0 while locked: nothing moves
        for (int i = 0; i < 3; i++) step(1'b0, e ^ 8'h5A, 1'b0);
        chk_all("locked_en0", 2'b10, 1'b1, 8'h00, 16'd1, 1'b0);

        // Lose lock, then stall mid-ACQUIRE
        for (int i = 0; i < 3; i++) begin
            step(1'b1, e ^ 8'h80, 1'b0); e++;
        end
        chk_all("lost2", 2'b11, 1'b0, 8'h03, 16'd1, 1'b1);
        step(1'b1, 8'h80, 1'b0);
        step(1'b1, 8'h81, 1'b0); chk("acq81", {14'd0, ifc.state}, 16'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h17 + i[7:0], 1'b0);
        chk("stall", {14'd0, ifc.state}, 16'd1);
        step(1'b1, 8'h82, 1'b0); chk("acq82", {14'd0, ifc.state}, 16'd1);
        step(1'b1, 8'h83, 1'b0); chk("lock83", {14'd0, ifc.state}, 16'd2);

        // Asynchronous reset mid-LOCKED
        step(1'b1, 8'h84, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 2'b00, 1'b0, 8'h00, 16'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 8'h85, 1'b0); chk("post_rst_idle", {14'd0, ifc.state}, 16'd0);
        step(1'b1, 8'h05, 1'b0); chk("post_rst_acq", {14'd0, ifc.state}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
